issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Issue-stage interlock controller for the micro-instruction pipeline.
- Consumes the per-instruction register usage fields (rut: from_gd/to_gd/from_gs/from_gt/from_ef/to_ef, d/s/t) and keeps a pending-write counter for each general register and for EFLAGS.
- Stalls issue on RAW hazards and on counter saturation, and releases on writeback.
- Provides flush and drain sequencing for branch mispredicts and serialising operations. Float register fields are handled by a separate FPU scoreboard and ignored here.

Parameters:
- NREG, 16, number of general registers tracked.
- RA_W, 4, register index width; must satisfy 2**RA_W >= NREG.
- CNT_W, 2, width of each pending counter; PMAX = 2**CNT_W-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- iss_valid  in  1  decoded micro-instruction offered for issue.
- iss_ready  out  1  scoreboard accepts; issue fires when iss_valid & iss_ready.
- iss_from_gd, iss_to_gd, iss_from_gs, iss_from_gt, iss_from_ef, iss_to_ef  in  1 each  rut usage flags.
- iss_d, iss_s, iss_t  in  RA_W each  rut register indices.
- wb0_valid, wb1_valid  in  1  writeback port strobes (port 0 = ALU, port 1 = load).
- wb0_to_gd, wb1_to_gd  in  1  port retires a GPR write.
- wb0_d, wb1_d  in  RA_W  destination retired.
- wb0_to_ef, wb1_to_ef  in  1  port retires an EFLAGS write.
- flush  in  1  squash all in-flight ops (pulse).
- drain_req  in  1  request to empty the pipeline (pulse).
- drain_done  out  1  one-cycle pulse when drain completes.
- busy  out  1  any counter non-zero.
- err  out  1  sticky underflow error.
- stall_cnt  out  32  saturating count of stalled cycles.

Behaviour:
- State: pend[0..NREG-1] (CNT_W each), pend_ef (CNT_W), FSM {RUN, DRAIN, RECOVER}.
- Reset (rstn=0 at posedge): all counters 0, FSM=RUN, err=0, stall_cnt=0, drain_done=0. During reset iss_ready=0 and busy=0.
- hazard = (from_gs & pend[s]!=0) | (from_gt & pend[t]!=0) | (from_gd & pend[d]!=0) | (from_ef & pend_ef!=0) | (to_gd & pend[d]==PMAX) | (to_ef & pend_ef==PMAX).
- iss_ready = (FSM==RUN) & ~hazard.
  - Combinational from registered state plus the iss_* inputs only.
  - No writeback bypass: a writeback in cycle N clears a hazard at the earliest in cycle N+1.
- Fire: if to_gd, pend[d]+=1; if to_ef, pend_ef+=1. Effective at the next posedge.
- Writeback, per port: if valid & to_gd, pend[d]-=1; if valid & to_ef, pend_ef-=1.
  - Both ports on the same register in one cycle: -2.
- Net update per counter = increments - decrements in the same cycle. Fire and writeback on the same register net 0.
- Underflow: a decrement below 0 clamps at 0 and sets err=1. err clears only on reset.
- An index >= NREG on any port is ignored for update and hazard, and sets err.
- FSM:
  - RUN: flush -> RECOVER. Otherwise drain_req -> DRAIN.
  - DRAIN: iss_ready=0. When all counters are 0 (post-update value) -> RUN and drain_done=1 that cycle. flush -> RECOVER.
  - RECOVER: entered with all counters cleared to 0 at the flush edge. Lasts exactly 1 cycle, iss_ready=0. Then -> RUN.
- flush has priority over fire, writeback, and drain_req in the same cycle. All counters become 0 regardless of the other inputs. A pending drain is abandoned, with no drain_done.
- drain_req while in DRAIN or RECOVER is ignored.
- busy = OR of all counters != 0 (registered state).
- stall_cnt increments when iss_valid & ~iss_ready in any non-reset cycle. It saturates at 2**32-1.

Test Plan:
- Reset, then issue ADD (to_gd, d=3, to_ef, from_ef) with no writeback -> pend[3]=1, pend_ef=1, busy=1. Next SUB with s=3 (from_gs) -> iss_ready=0. wb0 {d=3, to_ef} at cycle N -> iss_ready=1 at N+1, not N.
- Issue 3 MOVI to d=5 back-to-back (PMAX=3) -> 4th MOVI d=5 stalled, stall_cnt increments. One wb1 d=5 -> 4th accepted the following cycle, pend[5]=3.
- Fire MOVI d=7 in the same cycle as wb0 d=7 with pend[7]=1 -> pend[7] stays 1. wb0 and wb1 both on d=2 with pend[2]=2 -> pend[2]=0.
- pend[4]=2, drain_req -> iss_ready=0. Two writebacks over 5 cycles -> drain_done pulses exactly once, in the cycle pend[4] reaches 0; FSM back to RUN.
- In DRAIN with pend[1]=2, flush asserted together with a fire -> all counters 0, no drain_done. iss_ready=0 for 1 cycle, then 1.
- wb0 d=9 with pend[9]=0 -> pend[9] stays 0 and err=1 persists. wb with d=15 while NREG=12 -> err=1 and no counter changes.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Issue and writeback bundle between the decode/issue stage and the scoreboard.
interface issue_scoreboard_if #(
  parameter int unsigned RA_W = 4
);
  logic            iss_valid;
  logic            iss_ready;
  logic            iss_from_gd;
  logic            iss_to_gd;
  logic            iss_from_gs;
  logic            iss_from_gt;
  logic            iss_from_ef;
  logic            iss_to_ef;
  logic [RA_W-1:0] iss_d;
  logic [RA_W-1:0] iss_s;
  logic [RA_W-1:0] iss_t;
  logic            wb0_valid;
  logic            wb0_to_gd;
  logic [RA_W-1:0] wb0_d;
  logic            wb0_to_ef;
  logic            wb1_valid;
  logic            wb1_to_gd;
  logic [RA_W-1:0] wb1_d;
  logic            wb1_to_ef;

  modport master (
    output iss_valid, iss_from_gd, iss_to_gd, iss_from_gs, iss_from_gt,
           iss_from_ef, iss_to_ef, iss_d, iss_s, iss_t,
           wb0_valid, wb0_to_gd, wb0_d, wb0_to_ef,
           wb1_valid, wb1_to_gd, wb1_d, wb1_to_ef,
    input  iss_ready
  );

  modport slave (
    input  iss_valid, iss_from_gd, iss_to_gd, iss_from_gs, iss_from_gt,
           iss_from_ef, iss_to_ef, iss_d, iss_s, iss_t,
           wb0_valid, wb0_to_gd, wb0_d, wb0_to_ef,
           wb1_valid, wb1_to_gd, wb1_d, wb1_to_ef,
    output iss_ready
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue-stage interlock: per-register pending-write counters, RAW/saturation
// stalls, writeback release, flush/drain sequencing.
module issue_scoreboard #(
  parameter int unsigned NREG  = 16,
  parameter int unsigned RA_W  = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  issue_scoreboard_if.slave bus,
  input  logic              flush,
  input  logic              drain_req,
  output logic              drain_done,
  output logic              busy,
  output logic              err,
  output logic [31:0]       stall_cnt
);

  localparam int unsigned      SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] PMAX  = '1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pend_q   [NREG];
  logic [CNT_W-1:0] pend_d   [NREG];
  logic [CNT_W-1:0] pend_upd [NREG];
  logic [CNT_W-1:0] pend_ef_q, pend_ef_d, pend_ef_upd;
  logic             err_q, err_d;
  logic             drain_done_q, drain_done_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic hz_s, hz_t, hz_d_nz, hz_d_full, hazard;
  logic s_ok, t_ok, d_ok, wb0_d_ok, wb1_d_ok;
  logic any_nz, iss_ready, fire;
  logic underflow, cnt_zero, bad_idx;
  logic wb0_hit, wb1_hit;
  logic [CNT_W:0] res;

  // Clamp-at-zero counter update; MSB of the result flags an underflow.
  function automatic logic [CNT_W:0] apply_delta(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc,
                                                 input logic [1:0]       dec);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    if (sum < SUM_W'(dec)) apply_delta = {1'b1, {CNT_W{1'b0}}};
    else                   apply_delta = {1'b0, CNT_W'(sum - SUM_W'(dec))};
  endfunction

  // Hazard detection from registered counters; out-of-range indices match nothing.
  always_comb begin
    hz_s      = 1'b0;
    hz_t      = 1'b0;
    hz_d_nz   = 1'b0;
    hz_d_full = 1'b0;
    s_ok      = 1'b0;
    t_ok      = 1'b0;
    d_ok      = 1'b0;
    any_nz    = (pend_ef_q != '0);
    for (int unsigned r = 0; r < NREG; r++) begin
      if (bus.iss_s == RA_W'(r)) begin
        s_ok = 1'b1;
        if (pend_q[r] != '0) hz_s = 1'b1;
      end
      if (bus.iss_t == RA_W'(r)) begin
        t_ok = 1'b1;
        if (pend_q[r] != '0) hz_t = 1'b1;
      end
      if (bus.iss_d == RA_W'(r)) begin
        d_ok = 1'b1;
        if (pend_q[r] != '0) hz_d_nz = 1'b1;
        if (pend_q[r] == PMAX) hz_d_full = 1'b1;
      end
      if (pend_q[r] != '0) any_nz = 1'b1;
    end
    hazard = (bus.iss_from_gs & hz_s) | (bus.iss_from_gt & hz_t) |
             (bus.iss_from_gd & hz_d_nz) | (bus.iss_from_ef & (pend_ef_q != '0)) |
             (bus.iss_to_gd & hz_d_full) | (bus.iss_to_ef & (pend_ef_q == PMAX));
    iss_ready = rstn & (state_q == RUN) & ~hazard;
    fire      = bus.iss_valid & iss_ready;
  end

  // Net counter update from fire and both writeback ports; flush clears all.
  always_comb begin
    underflow = 1'b0;
    cnt_zero  = 1'b1;
    wb0_d_ok  = 1'b0;
    wb1_d_ok  = 1'b0;
    wb0_hit   = 1'b0;
    wb1_hit   = 1'b0;
    res       = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (bus.wb0_d == RA_W'(r)) wb0_d_ok = 1'b1;
      if (bus.wb1_d == RA_W'(r)) wb1_d_ok = 1'b1;
      wb0_hit = bus.wb0_valid & bus.wb0_to_gd & (bus.wb0_d == RA_W'(r));
      wb1_hit = bus.wb1_valid & bus.wb1_to_gd & (bus.wb1_d == RA_W'(r));
      res = apply_delta(pend_q[r], fire & bus.iss_to_gd & (bus.iss_d == RA_W'(r)),
                        {1'b0, wb0_hit} + {1'b0, wb1_hit});
      pend_upd[r] = res[CNT_W-1:0];
      if (res[CNT_W]) underflow = 1'b1;
      if (res[CNT_W-1:0] != '0) cnt_zero = 1'b0;
      pend_d[r] = flush ? '0 : res[CNT_W-1:0];
    end
    res = apply_delta(pend_ef_q, fire & bus.iss_to_ef,
                      {1'b0, bus.wb0_valid & bus.wb0_to_ef} +
                      {1'b0, bus.wb1_valid & bus.wb1_to_ef});
    pend_ef_upd = res[CNT_W-1:0];
    if (res[CNT_W]) underflow = 1'b1;
    if (res[CNT_W-1:0] != '0) cnt_zero = 1'b0;
    pend_ef_d = flush ? '0 : pend_ef_upd;

    bad_idx = (fire & ((bus.iss_from_gs & ~s_ok) | (bus.iss_from_gt & ~t_ok) |
                       ((bus.iss_from_gd | bus.iss_to_gd) & ~d_ok))) |
              (bus.wb0_valid & bus.wb0_to_gd & ~wb0_d_ok) |
              (bus.wb1_valid & bus.wb1_to_gd & ~wb1_d_ok);
    err_d = err_q | (~flush & (underflow | bad_idx));
    stall_cnt_d = (bus.iss_valid & ~iss_ready & (stall_cnt_q != '1)) ?
                  stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  // Run/drain/recover sequencing; flush always wins and abandons a drain.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (flush)          state_d = RECOVER;
        else if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (flush) begin
          state_d = RECOVER;
        end else if (cnt_zero) begin
          state_d      = RUN;
          drain_done_d = 1'b1;
        end
      end
      RECOVER: begin
        state_d = flush ? RECOVER : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= RUN;
      pend_ef_q    <= '0;
      err_q        <= 1'b0;
      drain_done_q <= 1'b0;
      stall_cnt_q  <= '0;
      for (int unsigned r = 0; r < NREG; r++) pend_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      pend_ef_q    <= pend_ef_d;
      err_q        <= err_d;
      drain_done_q <= drain_done_d;
      stall_cnt_q  <= stall_cnt_d;
      for (int unsigned r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
    end
  end

  assign bus.iss_ready = iss_ready;
  assign busy          = rstn & any_nz;
  assign err           = err_q;
  assign drain_done    = drain_done_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomised + directed bench for issue_scoreboard against a counter-array model.
module tb_issue_scoreboard;

  localparam int NREG = 12;
  localparam int PMAX = 3;
  localparam longint SMAX = 64'hFFFF_FFFF;

  typedef struct packed {
    bit rstn, valid, from_gd, to_gd, from_gs, from_gt, from_ef, to_ef;
    bit [3:0] d, s, t;
    bit wb0_valid, wb0_to_gd, wb0_to_ef;
    bit [3:0] wb0_d;
    bit wb1_valid, wb1_to_gd, wb1_to_ef;
    bit [3:0] wb1_d;
    bit flush, drain_req;
  } stim_t;

  typedef struct {
    bit     ready, busy, err, dd;
    longint stall;
    int     cyc;
  } exp_t;

  logic clk, rstn, flush, drain_req;
  logic drain_done, busy, err;
  logic [31:0] stall_cnt;

  issue_scoreboard_if #(.RA_W(4)) bus ();

  issue_scoreboard #(.NREG(NREG), .RA_W(4), .CNT_W(2)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .flush(flush), .drain_req(drain_req),
    .drain_done(drain_done), .busy(busy), .err(err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer counters and a couple of mode flags.
  int     m_pend [NREG];
  int     m_ef;
  bit     m_drain, m_recov, m_err, m_dd;
  longint m_stall;
  int     cycle;
  int     total, bad;
  exp_t   exp_q[$];

  function automatic bit ok(input bit [3:0] i);
    return int'(i) < NREG;
  endfunction

  function automatic bit exp_ready(input stim_t s);
    bit hz;
    if (!s.rstn || m_drain || m_recov) return 1'b0;
    hz = (s.from_gs && ok(s.s) && m_pend[s.s] != 0) ||
         (s.from_gt && ok(s.t) && m_pend[s.t] != 0) ||
         (s.from_gd && ok(s.d) && m_pend[s.d] != 0) ||
         (s.from_ef && m_ef != 0) ||
         (s.to_gd && ok(s.d) && m_pend[s.d] == PMAX) ||
         (s.to_ef && m_ef == PMAX);
    return !hz;
  endfunction

  function automatic bit any_pending();
    if (m_ef != 0) return 1'b1;
    foreach (m_pend[r]) if (m_pend[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    foreach (m_pend[r]) m_pend[r] = 0;
    m_ef = 0;
  endtask

  task automatic model_step(input stim_t s, input bit rdy);
    int np [NREG];
    int nef;
    bit fire;
    if (!s.rstn) begin
      model_clear();
      m_err = 0; m_stall = 0; m_dd = 0; m_drain = 0; m_recov = 0;
      return;
    end
    if (s.valid && !rdy && m_stall < SMAX) m_stall++;
    if (s.flush) begin
      model_clear();
      m_recov = 1; m_drain = 0; m_dd = 0;
      return;
    end
    fire = s.valid && rdy;
    foreach (np[r]) np[r] = m_pend[r];
    nef = m_ef;
    if (fire && s.to_gd && ok(s.d)) np[s.d]++;
    if (fire && s.to_ef) nef++;
    if (s.wb0_valid && s.wb0_to_gd) begin
      if (ok(s.wb0_d)) np[s.wb0_d]--; else m_err = 1;
    end
    if (s.wb1_valid && s.wb1_to_gd) begin
      if (ok(s.wb1_d)) np[s.wb1_d]--; else m_err = 1;
    end
    if (s.wb0_valid && s.wb0_to_ef) nef--;
    if (s.wb1_valid && s.wb1_to_ef) nef--;
    if (fire && ((s.from_gs && !ok(s.s)) || (s.from_gt && !ok(s.t)) ||
                 ((s.from_gd || s.to_gd) && !ok(s.d)))) m_err = 1;
    foreach (np[r]) begin
      if (np[r] < 0) begin np[r] = 0; m_err = 1; end
      m_pend[r] = np[r];
    end
    if (nef < 0) begin nef = 0; m_err = 1; end
    m_ef = nef;
    m_dd = 0;
    if (m_recov) m_recov = 0;
    else if (m_drain) begin
      if (!any_pending()) begin m_drain = 0; m_dd = 1; end
    end else if (s.drain_req) m_drain = 1;
  endtask

  task automatic apply(input stim_t s);
    rstn            = s.rstn;
    flush           = s.flush;
    drain_req       = s.drain_req;
    bus.iss_valid   = s.valid;
    bus.iss_from_gd = s.from_gd;
    bus.iss_to_gd   = s.to_gd;
    bus.iss_from_gs = s.from_gs;
    bus.iss_from_gt = s.from_gt;
    bus.iss_from_ef = s.from_ef;
    bus.iss_to_ef   = s.to_ef;
    bus.iss_d       = s.d;
    bus.iss_s       = s.s;
    bus.iss_t       = s.t;
    bus.wb0_valid   = s.wb0_valid;
    bus.wb0_to_gd   = s.wb0_to_gd;
    bus.wb0_d       = s.wb0_d;
    bus.wb0_to_ef   = s.wb0_to_ef;
    bus.wb1_valid   = s.wb1_valid;
    bus.wb1_to_gd   = s.wb1_to_gd;
    bus.wb1_d       = s.wb1_d;
    bus.wb1_to_ef   = s.wb1_to_ef;
  endtask

  // Drive one cycle, queue its expected outputs, then advance the model.
  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    cycle++;
    e.ready = exp_ready(s);
    e.busy  = s.rstn && any_pending();
    e.err   = m_err;
    e.dd    = m_dd;
    e.stall = m_stall;
    e.cyc   = cycle;
    exp_q.push_back(e);
    model_step(s, e.ready);
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    s.rstn = 1'b1;
    return s;
  endfunction

  function automatic stim_t movi(input bit [3:0] d);
    stim_t s;
    s = nop();
    s.valid = 1'b1; s.to_gd = 1'b1; s.d = d;
    return s;
  endfunction

  function automatic stim_t wb0(input stim_t b, input bit [3:0] d, input bit ef);
    stim_t s;
    s = b;
    s.wb0_valid = 1'b1; s.wb0_to_gd = 1'b1; s.wb0_d = d; s.wb0_to_ef = ef;
    return s;
  endfunction

  function automatic stim_t wb1(input stim_t b, input bit [3:0] d);
    stim_t s;
    s = b;
    s.wb1_valid = 1'b1; s.wb1_to_gd = 1'b1; s.wb1_d = d;
    return s;
  endfunction

  task automatic do_reset(input int n);
    stim_t s;
    s = '0;
    for (int i = 0; i < n; i++) step(s);
  endtask

  task automatic chk(input string name, input longint act, input longint want, input int cyc);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, want);
    end
  endtask

  // Monitor: pops one expected record per cycle and compares mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("iss_ready",  longint'(bus.iss_ready), longint'(e.ready), e.cyc);
        chk("busy",       longint'(busy),          longint'(e.busy),  e.cyc);
        chk("err",        longint'(err),           longint'(e.err),   e.cyc);
        chk("drain_done", longint'(drain_done),    longint'(e.dd),    e.cyc);
        chk("stall_cnt",  longint'(stall_cnt),     e.stall,           e.cyc);
      end
    end
  end

  task automatic rand_phase(input int n, input bit wild);
    stim_t s;
    int    r;
    for (int c = 0; c < n; c++) begin
      s = nop();
      s.valid   = ($urandom_range(0, 9) < 7);
      s.from_gd = ($urandom_range(0, 9) < 2);
      s.to_gd   = ($urandom_range(0, 9) < 6);
      s.from_gs = ($urandom_range(0, 9) < 4);
      s.from_gt = ($urandom_range(0, 9) < 3);
      s.from_ef = ($urandom_range(0, 9) < 2);
      s.to_ef   = ($urandom_range(0, 9) < 3);
      s.d = 4'($urandom_range(0, wild ? 15 : NREG - 1));
      s.s = 4'($urandom_range(0, wild ? 15 : NREG - 1));
      s.t = 4'($urandom_range(0, wild ? 15 : NREG - 1));
      if ($urandom_range(0, 9) < 4) begin
        r = $urandom_range(0, wild ? 15 : NREG - 1);
        if (wild || m_pend[r] > 0) s = wb0(s, 4'(r), 1'b0);
        s.wb0_to_ef = (m_ef > 0 || wild) && $urandom_range(0, 1) == 1;
        s.wb0_valid = s.wb0_valid | s.wb0_to_ef;
      end
      if ($urandom_range(0, 9) < 3) begin
        r = $urandom_range(0, wild ? 15 : NREG - 1);
        if (wild || m_pend[r] > 0) s = wb1(s, 4'(r));
      end
      s.flush     = ($urandom_range(0, 49) == 0);
      s.drain_req = ($urandom_range(0, 24) == 0);
      step(s);
    end
  endtask

  initial begin
    stim_t s, add, sub, rd7;
    total = 0; bad = 0; cycle = 0;
    model_clear();
    m_err = 0; m_stall = 0; m_dd = 0; m_drain = 0; m_recov = 0;
    rstn = 1'b0;
    apply('0);
    do_reset(3);

    // RAW on r3 and EFLAGS; writeback releases one cycle later.
    add = movi(4'd3); add.to_ef = 1'b1; add.from_ef = 1'b1;
    step(add);
    sub = movi(4'd4); sub.from_gs = 1'b1; sub.s = 4'd3;
    step(sub); step(sub);
    step(wb0(sub, 4'd3, 1'b1));
    step(sub);
    step(wb0(nop(), 4'd4, 1'b0));

    // Saturation on r5.
    for (int i = 0; i < 5; i++) step(movi(4'd5));
    step(wb1(movi(4'd5), 4'd5));
    step(movi(4'd5));
    for (int i = 0; i < 3; i++) step(wb1(nop(), 4'd5));

    // Fire and writeback on the same register net to zero; dual writeback.
    step(movi(4'd7));
    step(wb0(movi(4'd7), 4'd7, 1'b0));
    rd7 = nop(); rd7.valid = 1'b1; rd7.from_gs = 1'b1; rd7.s = 4'd7;
    step(rd7);
    step(wb0(rd7, 4'd7, 1'b0));
    step(rd7);
    step(movi(4'd2)); step(movi(4'd2));
    step(wb1(wb0(nop(), 4'd2, 1'b0), 4'd2));
    step(nop());

    // Drain completes after two writebacks.
    step(movi(4'd4)); step(movi(4'd4));
    s = nop(); s.drain_req = 1'b1; step(s);
    step(movi(4'd1));
    step(wb0(movi(4'd1), 4'd4, 1'b0));
    step(movi(4'd1));
    step(wb1(movi(4'd1), 4'd4));
    step(movi(4'd1));
    step(nop());
    step(wb0(nop(), 4'd1, 1'b0));

    // Flush during drain with a fire attempt.
    step(movi(4'd1)); step(movi(4'd1));
    s = nop(); s.drain_req = 1'b1; step(s);
    s = movi(4'd3); s.flush = 1'b1; step(s);
    step(movi(4'd3)); step(movi(4'd3));
    step(wb0(nop(), 4'd3, 1'b0));
    step(nop());

    // Underflow and out-of-range indices.
    step(wb0(nop(), 4'd9, 1'b0));
    step(nop()); step(nop());
    do_reset(2);
    step(movi(4'd15));
    step(nop());
    do_reset(2);
    step(wb0(nop(), 4'd15, 1'b0));
    step(nop());

    do_reset(2);
    rand_phase(1500, 1'b0);
    do_reset(2);
    rand_phase(1000, 1'b1);
    step(nop());

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
